// File: rtl/case_7_prod_accum.sv
// case_7_prod_accum: sums a run of len signed products into a saturating signed
// accumulator and returns the result over a valid/ready port under ap_* control.
module case_7_prod_accum #(
   parameter int PROD_W = 11,
   parameter int ACC_W  = 16,
   parameter int LEN_W  = 8
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              ap_start,
   output logic              ap_ready,
   output logic              ap_idle,
   output logic              ap_done,
   input  logic [LEN_W-1:0]  len,
   input  logic [PROD_W-1:0] prod_dat,
   input  logic              prod_vld,
   output logic              prod_rdy,
   output logic [ACC_W-1:0]  acc_dat,
   output logic              acc_vld,
   input  logic              acc_rdy,
   output logic              sat_flag
);

   typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] len_q;
   logic [ACC_W:0]   sum;
   logic             sum_ovf;
   logic [ACC_W-1:0] sum_sat;
   logic             take;
   logic             last;

   assign take = prod_vld && (state == RUN);
   assign last = (cnt == (len_q - LEN_ONE));

   // One guard bit is enough: overflow shows up as the two top bits disagreeing.
   assign sum     = {acc[ACC_W-1], acc}
                  + {{(ACC_W+1-PROD_W){prod_dat[PROD_W-1]}}, prod_dat};
   assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
   assign sum_sat = !sum_ovf ? sum[ACC_W-1:0] : (sum[ACC_W] ? ACC_MIN : ACC_MAX);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (ap_start) state_nxt = (len == '0) ? OUT : RUN;
         RUN:  if (take && last) state_nxt = OUT;
         OUT:  if (acc_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ap_idle  = (state == IDLE);
      ap_ready = (state == IDLE) && ap_start;
      prod_rdy = (state == RUN);
      acc_vld  = (state == OUT);
      ap_done  = (state == OUT) && acc_rdy;
      acc_dat  = acc;
   end

   // A new start clears the previous run's sum and sticky flag.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc      <= '0;
         cnt      <= '0;
         len_q    <= '0;
         sat_flag <= 1'b0;
      end else if ((state == IDLE) && ap_start) begin
         acc      <= '0;
         cnt      <= '0;
         len_q    <= len;
         sat_flag <= 1'b0;
      end else if (take) begin
         acc <= sum_sat;
         cnt <= cnt + LEN_ONE;
         if (sum_ovf) begin
            sat_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_case_7_prod_accum.sv
// Self-checking bench for case_7_prod_accum: directed scenarios plus random runs,
// compared against an integer clamp-and-add reference model.
module tb_case_7_prod_accum;

   logic        ap_clk   = 1'b0;
   logic        ap_rst_n = 1'b1;
   logic        ap_start = 1'b0;
   logic [7:0]  len      = '0;
   logic [10:0] prod_dat = '0;
   logic        prod_vld = 1'b0;
   logic        acc_rdy  = 1'b0;
   logic        ap_ready;
   logic        ap_idle;
   logic        ap_done;
   logic        prod_rdy;
   logic [15:0] acc_dat;
   logic        acc_vld;
   logic        sat_flag;

   int n_checks = 0;
   int n_pass   = 0;
   int prods[256];

   case_7_prod_accum #(.PROD_W(11), .ACC_W(16), .LEN_W(8)) dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .ap_start (ap_start),
      .ap_ready (ap_ready),
      .ap_idle  (ap_idle),
      .ap_done  (ap_done),
      .len      (len),
      .prod_dat (prod_dat),
      .prod_vld (prod_vld),
      .prod_rdy (prod_rdy),
      .acc_dat  (acc_dat),
      .acc_vld  (acc_vld),
      .acc_rdy  (acc_rdy),
      .sat_flag (sat_flag)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: plain integer running sum, clamped to the 16-bit signed range.
   function automatic void ref_run(input int n, output logic [15:0] exp_sum, output logic exp_sat);
      int s;
      s       = 0;
      exp_sat = 1'b0;
      for (int i = 0; i < n; i++) begin
         s = s + prods[i];
         if (s > 32767) begin
            s = 32767;
            exp_sat = 1'b1;
         end else if (s < -32768) begin
            s = -32768;
            exp_sat = 1'b1;
         end
      end
      exp_sum = s[15:0];
   endfunction

   // Drives one full run and reports the result plus a count of protocol anomalies.
   task automatic do_run(input int n, input int gap_pct, input int bp,
                         output logic [15:0] res, output logic sat, output int anom);
      int i;
      int guard;
      logic [15:0] held;
      anom = 0;
      @(negedge ap_clk);
      len      = n[7:0];
      ap_start = 1'b1;
      #1;
      if (ap_ready !== 1'b1 || ap_idle !== 1'b1) anom++;
      @(negedge ap_clk);
      ap_start = 1'b0;
      len      = 8'($urandom);
      i        = 0;
      guard    = 0;
      while (i < n && guard < 2000) begin
         prod_vld = (int'($urandom_range(99)) >= gap_pct);
         prod_dat = prod_vld ? prods[i][10:0] : 11'($urandom);
         #1;
         if (prod_rdy !== 1'b1 || acc_vld !== 1'b0 || ap_idle !== 1'b0 || ap_ready !== 1'b0) anom++;
         @(negedge ap_clk);
         if (prod_vld) i++;
         guard++;
      end
      prod_vld = 1'b0;
      #1;
      if (i < n) anom++;
      if (acc_vld !== 1'b1 || prod_rdy !== 1'b0) anom++;
      held = acc_dat;
      for (int k = 0; k < bp; k++) begin
         acc_rdy = 1'b0;
         #1;
         if (acc_vld !== 1'b1 || acc_dat !== held || ap_done !== 1'b0 || prod_rdy !== 1'b0) anom++;
         @(negedge ap_clk);
      end
      acc_rdy = 1'b1;
      #1;
      if (acc_vld !== 1'b1 || ap_done !== 1'b1 || acc_dat !== held) anom++;
      res = acc_dat;
      sat = sat_flag;
      @(negedge ap_clk);
      acc_rdy = 1'b0;
      #1;
      if (ap_idle !== 1'b1 || acc_vld !== 1'b0 || ap_done !== 1'b0) anom++;
   endtask

   task automatic test_reset();
      #2 ap_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ap_idle, ap_ready, ap_done, prod_rdy, acc_vld, sat_flag} !== 6'b100000)
         $display("[TB] FAIL reset_ctrl: got %b expected 100000", {ap_idle, ap_ready, ap_done, prod_rdy, acc_vld, sat_flag});
      else n_pass++;
      n_checks++;
      if (acc_dat !== 16'd0) $display("[TB] FAIL reset_acc: got %0d expected 0", acc_dat);
      else n_pass++;
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [15:0] res, exp_sum;
      logic sat, exp_sat;
      int anom;
      prods[0] = 3; prods[1] = -5; prods[2] = 10; prods[3] = -1;
      ref_run(4, exp_sum, exp_sat);
      do_run(4, 0, 0, res, sat, anom);
      n_checks++;
      if (res !== exp_sum) $display("[TB] FAIL basic_sum: got %0d expected %0d", $signed(res), $signed(exp_sum));
      else n_pass++;
      n_checks++;
      if (sat !== exp_sat) $display("[TB] FAIL basic_sat: got %b expected %b", sat, exp_sat);
      else n_pass++;
      n_checks++;
      if (anom !== 0) $display("[TB] FAIL basic_protocol: got %0d anomalies expected 0", anom);
      else n_pass++;
   endtask

   task automatic test_len_zero();
      logic [15:0] res;
      logic sat;
      int anom;
      do_run(0, 0, 2, res, sat, anom);
      n_checks++;
      if (res !== 16'd0) $display("[TB] FAIL len0_sum: got %0d expected 0", $signed(res));
      else n_pass++;
      n_checks++;
      if (anom !== 0) $display("[TB] FAIL len0_protocol: got %0d anomalies expected 0", anom);
      else n_pass++;
   endtask

   task automatic test_saturation();
      logic [15:0] res, exp_sum;
      logic sat, exp_sat;
      int anom;
      for (int pass = 0; pass < 3; pass++) begin
         for (int i = 0; i < 40; i++) prods[i] = (pass == 0) ? 1023 : (pass == 1) ? -1024 : (i % 7) - 3;
         ref_run(40, exp_sum, exp_sat);
         do_run(40, 0, 1, res, sat, anom);
         n_checks++;
         if (res !== exp_sum) $display("[TB] FAIL sat_sum%0d: got %0d expected %0d", pass, $signed(res), $signed(exp_sum));
         else n_pass++;
         n_checks++;
         if (sat !== exp_sat) $display("[TB] FAIL sat_flag%0d: got %b expected %b", pass, sat, exp_sat);
         else n_pass++;
         n_checks++;
         if (anom !== 0) $display("[TB] FAIL sat_protocol%0d: got %0d anomalies expected 0", pass, anom);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] res, exp_sum;
      logic sat, exp_sat;
      int anom;
      for (int i = 0; i < 6; i++) prods[i] = int'($urandom_range(2047)) - 1024;
      ref_run(6, exp_sum, exp_sat);
      do_run(6, 50, 5, res, sat, anom);
      n_checks++;
      if (res !== exp_sum) $display("[TB] FAIL bp_sum: got %0d expected %0d", $signed(res), $signed(exp_sum));
      else n_pass++;
      n_checks++;
      if (anom !== 0) $display("[TB] FAIL bp_protocol: got %0d anomalies expected 0", anom);
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      logic [15:0] res, exp_sum;
      logic sat, exp_sat;
      int anom;
      @(negedge ap_clk);
      len = 8'd4; ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         prod_vld = 1'b1;
         prod_dat = 11'(100 * (i + 1));
         @(negedge ap_clk);
      end
      prod_vld = 1'b0;
      ap_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ap_idle, ap_ready, ap_done, prod_rdy, acc_vld, sat_flag} !== 6'b100000)
         $display("[TB] FAIL midrst_ctrl: got %b expected 100000", {ap_idle, ap_ready, ap_done, prod_rdy, acc_vld, sat_flag});
      else n_pass++;
      n_checks++;
      if (acc_dat !== 16'd0) $display("[TB] FAIL midrst_acc: got %0d expected 0", $signed(acc_dat));
      else n_pass++;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      prods[0] = 5; prods[1] = 6;
      ref_run(2, exp_sum, exp_sat);
      do_run(2, 0, 0, res, sat, anom);
      n_checks++;
      if (res !== exp_sum || anom !== 0)
         $display("[TB] FAIL midrst_rerun: got %0d (anom %0d) expected %0d (anom 0)", $signed(res), anom, $signed(exp_sum));
      else n_pass++;
   endtask

   task automatic test_start_held();
      int anom;
      anom = 0;
      @(negedge ap_clk);
      len = 8'd3; ap_start = 1'b1;
      #1;
      n_checks++;
      if (ap_ready !== 1'b1) $display("[TB] FAIL held_ready1: got %b expected 1", ap_ready);
      else n_pass++;
      @(negedge ap_clk);
      len = 8'd1;
      for (int k = 0; k < 3; k++) begin
         prod_vld = 1'b1;
         prod_dat = (k == 0) ? 11'd7 : (k == 1) ? 11'd8 : -11'sd20;
         #1;
         if (ap_ready !== 1'b0 || prod_rdy !== 1'b1) anom++;
         @(negedge ap_clk);
      end
      prod_vld = 1'b0;
      acc_rdy  = 1'b1;
      #1;
      n_checks++;
      if (ap_done !== 1'b1 || ap_ready !== 1'b0 || acc_dat !== -16'sd5 || anom !== 0)
         $display("[TB] FAIL held_run1: got done %b ready %b sum %0d anom %0d expected 1 0 -5 0",
                  ap_done, ap_ready, $signed(acc_dat), anom);
      else n_pass++;
      @(negedge ap_clk);
      acc_rdy = 1'b0;
      #1;
      n_checks++;
      if (ap_ready !== 1'b1 || ap_idle !== 1'b1) $display("[TB] FAIL held_restart: got ready %b idle %b expected 1 1", ap_ready, ap_idle);
      else n_pass++;
      @(negedge ap_clk);
      ap_start = 1'b0;
      len      = 8'd9;
      prod_vld = 1'b1;
      prod_dat = 11'd123;
      @(negedge ap_clk);
      prod_vld = 1'b0;
      acc_rdy  = 1'b1;
      #1;
      n_checks++;
      if (acc_vld !== 1'b1 || ap_done !== 1'b1 || acc_dat !== 16'd123)
         $display("[TB] FAIL held_run2: got vld %b done %b sum %0d expected 1 1 123", acc_vld, ap_done, $signed(acc_dat));
      else n_pass++;
      @(negedge ap_clk);
      acc_rdy = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] res, exp_sum;
      logic sat, exp_sat;
      int anom, n, big;
      for (int r = 0; r < 10; r++) begin
         n   = int'($urandom_range(30));
         big = int'($urandom_range(2));
         for (int i = 0; i < n; i++) begin
            if (big == 1)      prods[i] = 900 + int'($urandom_range(123));
            else if (big == 2) prods[i] = -900 - int'($urandom_range(124));
            else               prods[i] = int'($urandom_range(2047)) - 1024;
         end
         ref_run(n, exp_sum, exp_sat);
         do_run(n, int'($urandom_range(40)), int'($urandom_range(3)), res, sat, anom);
         n_checks++;
         if (res !== exp_sum) $display("[TB] FAIL rand%0d_sum: got %0d expected %0d", r, $signed(res), $signed(exp_sum));
         else n_pass++;
         n_checks++;
         if (sat !== exp_sat) $display("[TB] FAIL rand%0d_sat: got %b expected %b", r, sat, exp_sat);
         else n_pass++;
         n_checks++;
         if (anom !== 0) $display("[TB] FAIL rand%0d_protocol: got %0d anomalies expected 0", r, anom);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_saturation();
      test_backpressure();
      test_reset_mid_run();
      test_start_held();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
